// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: rotate helpers, sigma rotate/shift amounts, round-count lookup and
// the message-schedule FSM state type.
package sha2_pkg;

   typedef enum logic [0:0] {IDLE, STREAM} MsaSchedState;

   // sigma0 / sigma1 for 32-bit words
   localparam int unsigned S0_R1_32 = 7;
   localparam int unsigned S0_R2_32 = 18;
   localparam int unsigned S0_SH_32 = 3;
   localparam int unsigned S1_R1_32 = 17;
   localparam int unsigned S1_R2_32 = 19;
   localparam int unsigned S1_SH_32 = 10;

   // sigma0 / sigma1 for 64-bit words
   localparam int unsigned S0_R1_64 = 1;
   localparam int unsigned S0_R2_64 = 8;
   localparam int unsigned S0_SH_64 = 7;
   localparam int unsigned S1_R1_64 = 19;
   localparam int unsigned S1_R2_64 = 61;
   localparam int unsigned S1_SH_64 = 6;

   function automatic logic [31:0] rightRotate32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [63:0] rightRotate64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic int unsigned msa_rounds(input int unsigned word_w);
      return (word_w == 64) ? 80 : 64;
   endfunction

endpackage

// File: rtl/msa_sigma.sv
// One SHA-2 schedule word: sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] mod 2^WORD_W.
module msa_sigma
   import sha2_pkg::*;
#(
   parameter int unsigned WORD_W = 32
) (
   input  logic [WORD_W-1:0] w_m2,
   input  logic [WORD_W-1:0] w_m7,
   input  logic [WORD_W-1:0] w_m15,
   input  logic [WORD_W-1:0] w_m16,
   output logic [WORD_W-1:0] w_new
);

   logic [WORD_W-1:0] s0;
   logic [WORD_W-1:0] s1;

   if (WORD_W == 64) begin : g_w64
      assign s0 = rightRotate64(w_m15, S0_R1_64) ^ rightRotate64(w_m15, S0_R2_64)
                ^ (w_m15 >> S0_SH_64);
      assign s1 = rightRotate64(w_m2, S1_R1_64) ^ rightRotate64(w_m2, S1_R2_64)
                ^ (w_m2 >> S1_SH_64);
   end else begin : g_w32
      assign s0 = rightRotate32(w_m15, S0_R1_32) ^ rightRotate32(w_m15, S0_R2_32)
                ^ (w_m15 >> S0_SH_32);
      assign s1 = rightRotate32(w_m2, S1_R1_32) ^ rightRotate32(w_m2, S1_R2_32)
                ^ (w_m2 >> S1_SH_32);
   end

   assign w_new = s1 + w_m7 + s0 + w_m16;

endmodule

// File: rtl/msa_scheduler.sv
// Streaming SHA-2 message-schedule generator over a rolling 16-word window, LANES words per beat.
// Optional MSA_SCHED_PERF_EN adds perf_chunks / perf_stalls counters.
module msa_scheduler
   import sha2_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned LANES  = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      chunk_vld,
   output logic                      chunk_rdy,
   input  logic [16*WORD_W-1:0]      chunk_data,
   output logic                      w_vld,
   input  logic                      w_rdy,
   output logic [LANES*WORD_W-1:0]   w_data,
   output logic [6:0]                w_idx,
   output logic                      w_last
`ifdef MSA_SCHED_PERF_EN
   ,
   output logic [31:0]               perf_chunks,
   output logic [31:0]               perf_stalls
`endif
);

   localparam int unsigned ROUNDS   = msa_rounds(WORD_W);
   localparam logic [6:0]  LAST_IDX = 7'(ROUNDS - LANES);
   localparam logic [6:0]  IDX_STEP = 7'(LANES);

   MsaSchedState      state_q, state_d;
   logic [6:0]        idx_q, idx_d;
   logic              rdy_en_q;
   logic              chunk_hs, beat_hs;
   logic [WORD_W-1:0] win_q   [16];
   logic [WORD_W-1:0] win_d   [16];
   logic [WORD_W-1:0] shifted [16];
   logic [WORD_W-1:0] fresh   [LANES];

   assign w_vld     = (state_q == STREAM);
   assign w_idx     = idx_q;
   assign w_last    = w_vld & (idx_q == LAST_IDX);
   assign beat_hs   = w_vld & w_rdy;
   // rdy_en_q keeps chunk_rdy low until the first edge after reset release
   assign chunk_rdy = rdy_en_q & ((state_q == IDLE) | (beat_hs & w_last));
   assign chunk_hs  = chunk_vld & chunk_rdy;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [WORD_W-1:0] w_m2;
      logic [WORD_W-1:0] w_new;
      // upper lanes take W[t-2] from the lane computed two positions earlier this cycle
      if (j < 2) begin : g_win
         assign w_m2 = win_q[14+j];
      end else begin : g_chain
         assign w_m2 = g_lane[j-2].w_new;
      end
      msa_sigma #(.WORD_W(WORD_W)) u_sigma (
         .w_m2  (w_m2),
         .w_m7  (win_q[9+j]),
         .w_m15 (win_q[1+j]),
         .w_m16 (win_q[j]),
         .w_new (w_new)
      );
      assign fresh[j]                     = w_new;
      assign w_data[j*WORD_W +: WORD_W]   = win_q[j];
   end

   for (genvar k = 0; k < 16; k++) begin : g_shift
      if (k + LANES < 16) begin : g_old
         assign shifted[k] = win_q[k+LANES];
      end else begin : g_new
         assign shifted[k] = fresh[k+LANES-16];
      end
   end

   always_comb begin
      for (int k = 0; k < 16; k++) win_d[k] = win_q[k];
      if (chunk_hs) begin
         for (int k = 0; k < 16; k++) win_d[k] = chunk_data[k*WORD_W +: WORD_W];
      end else if (beat_hs) begin
         for (int k = 0; k < 16; k++) win_d[k] = shifted[k];
      end
   end

   always_ff @(posedge clk) begin
      win_q <= win_d;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (chunk_hs) begin
               state_d = STREAM;
               idx_d   = '0;
            end
         end
         STREAM: begin
            if (beat_hs) begin
               if (chunk_hs) begin
                  idx_d = '0;
               end else if (w_last) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_STEP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rdy_en_q <= 1'b1;
      end
   end

`ifdef MSA_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_chunks <= '0;
         perf_stalls <= '0;
      end else begin
         if (chunk_hs) perf_chunks <= perf_chunks + 32'd1;
         if (w_vld & ~w_rdy) perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_msa_scheduler.sv
// Bench for msa_scheduler in three configurations (32/1, 32/2, 64/4) against a full-array
// SHA-2 schedule model; perf counters checked when MSA_SCHED_PERF_EN is defined.
module tb_msa_scheduler;

   logic clk = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
      logic [31:0] y;
      if (w == 32) begin
         y = x[31:0];
         return {32'h0, (y >> n) | (y << (32 - n))};
      end
      return (x >> n) | (x << (64 - n));
   endfunction

   // Whole schedule W[0..79] computed straight from the recurrence
   function automatic void build(input int w, input logic [63:0] m [16],
                                 output logic [63:0] s [80]);
      logic [63:0] mask, a, b, s0, s1;
      mask = (w == 32) ? 64'hFFFF_FFFF : {64{1'b1}};
      for (int i = 0; i < 16; i++) s[i] = m[i] & mask;
      for (int t = 16; t < 80; t++) begin
         a = s[t-15];
         b = s[t-2];
         if (w == 32) begin
            s0 = rotr(a, 7, 32) ^ rotr(a, 18, 32) ^ (a >> 3);
            s1 = rotr(b, 17, 32) ^ rotr(b, 19, 32) ^ (b >> 10);
         end else begin
            s0 = rotr(a, 1, 64) ^ rotr(a, 8, 64) ^ (a >> 7);
            s1 = rotr(b, 19, 64) ^ rotr(b, 61, 64) ^ (b >> 6);
         end
         s[t] = (s1 + s[t-7] + s0 + s[t-16]) & mask;
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int W = (g == 2) ? 64 : 32;
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      localparam int R = (W == 64) ? 80 : 64;

      logic             rst_n = 1'b1;
      logic             chunk_vld = 1'b0;
      logic             w_rdy = 1'b0;
      logic             en_m = 1'b0;
      logic             done = 1'b0;
      logic             chunk_rdy, w_vld, w_last;
      logic [16*W-1:0]  chunk_data = '0;
      logic [L*W-1:0]   w_data;
      logic [6:0]       w_idx;
      int               qi[$];
      logic [255:0]     qd[$];
      int               acc_m = 0;
      int               chunks_m = 0;
      int               stalls_m = 0;
`ifdef MSA_SCHED_PERF_EN
      logic [31:0]      perf_chunks, perf_stalls;
`endif

      msa_scheduler #(.WORD_W(W), .LANES(L)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .chunk_vld  (chunk_vld),
         .chunk_rdy  (chunk_rdy),
         .chunk_data (chunk_data),
         .w_vld      (w_vld),
         .w_rdy      (w_rdy),
         .w_data     (w_data),
         .w_idx      (w_idx),
         .w_last     (w_last)
`ifdef MSA_SCHED_PERF_EN
         ,
         .perf_chunks(perf_chunks),
         .perf_stalls(perf_stalls)
`endif
      );

      // Ready is allowed only from the first edge after reset release
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) en_m <= 1'b0;
         else        en_m <= 1'b1;
      end

      // Expected beats live in qi/qd; the head is what the DUT must be showing now
      always @(negedge clk) begin : p_cmp
         logic          exp_rdy;
         logic [63:0]   m [16];
         logic [63:0]   s [80];
         logic [255:0]  d;
         if (!rst_n) begin
            chk($sformatf("c%0d.rst_w_vld", g), w_vld, 1'b0);
            chk($sformatf("c%0d.rst_chunk_rdy", g), chunk_rdy, 1'b0);
            chk($sformatf("c%0d.rst_w_idx", g), w_idx, 7'd0);
            chk($sformatf("c%0d.rst_w_last", g), w_last, 1'b0);
            qi.delete();
            qd.delete();
            chunks_m = 0;
            stalls_m = 0;
         end else begin
            exp_rdy = en_m && (qi.size() == 0 || (qi.size() == 1 && w_rdy));
            chk($sformatf("c%0d.w_vld", g), w_vld, qi.size() != 0);
            chk($sformatf("c%0d.chunk_rdy", g), chunk_rdy, exp_rdy);
            if (qi.size() != 0) begin
               chk($sformatf("c%0d.w_idx", g), w_idx, qi[0]);
               chk($sformatf("c%0d.w_last", g), w_last, qi[0] == R - L);
               chk($sformatf("c%0d.w_data@%0d", g, qi[0]), w_data, qd[0]);
               if (w_rdy) begin
                  void'(qi.pop_front());
                  void'(qd.pop_front());
               end else begin
                  stalls_m++;
               end
            end
            if (chunk_vld && exp_rdy) begin
               for (int i = 0; i < 16; i++) m[i] = 64'(chunk_data[i*W +: W]);
               build(W, m, s);
               for (int b = 0; b < R / L; b++) begin
                  d = '0;
                  for (int j = 0; j < L; j++) d[j*W +: W] = s[b*L+j][W-1:0];
                  qi.push_back(b * L);
                  qd.push_back(d);
               end
               acc_m++;
               chunks_m++;
            end
         end
      end

      task automatic rand_chunk();
         logic [63:0] r;
         for (int i = 0; i < 16; i++) begin
            r = {$urandom(), $urandom()};
            chunk_data[i*W +: W] = r[W-1:0];
         end
      endtask

      task automatic offer(input logic keep);
         int start;
         start = acc_m;
         chunk_vld = 1'b1;
         for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (acc_m != start) break;
         end
         chk($sformatf("c%0d.accept", g), acc_m != start, 1'b1);
         chunk_vld = keep;
      endtask

      task automatic drain();
         w_rdy = 1'b1;
         for (int k = 0; k < 600 && qi.size() != 0; k++) begin
            @(posedge clk);
            #1;
         end
         chk($sformatf("c%0d.drain", g), qi.size() == 0, 1'b1);
      endtask

      task automatic perf_check();
`ifdef MSA_SCHED_PERF_EN
         chk($sformatf("c%0d.perf_chunks", g), perf_chunks, 32'(chunks_m));
         chk($sformatf("c%0d.perf_stalls", g), perf_stalls, 32'(stalls_m));
`endif
      endtask

      initial begin : p_stim
         logic [63:0] r;
         #1 rst_n = 1'b0;
         repeat (3) @(posedge clk);
         #1 rst_n = 1'b1;
         w_rdy = 1'b1;

         // "abc" single-block message
         chunk_data = '0;
         r = (W == 32) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
         chunk_data[W-1:0] = r[W-1:0];
         chunk_data[15*W +: W] = W'(24);
         offer(1'b0);
         drain();
         perf_check();

         chunk_data = '0;
         offer(1'b0);
         drain();

         // back-to-back: second chunk held valid through the whole first stream
         rand_chunk();
         offer(1'b1);
         rand_chunk();
         offer(1'b0);
         drain();
         perf_check();

         for (int c = 0; c < 300; c++) begin
            w_rdy = 1'($urandom() % 2);
            chunk_vld = (($urandom() % 3) == 0);
            rand_chunk();
            @(posedge clk);
            #1;
         end
         chunk_vld = 1'b0;
         drain();
         perf_check();

         // reset in the middle of a stream
         rand_chunk();
         offer(1'b0);
         for (int k = 0; k < 100; k++) begin
            if (qi.size() != 0 && qi[0] == 20) break;
            @(posedge clk);
            #1;
         end
         chk($sformatf("c%0d.reach20", g), w_idx, 7'd20);
         #2 rst_n = 1'b0;
         #1 chk($sformatf("c%0d.async_drop", g), w_vld, 1'b0);
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
         @(posedge clk);
         #1 chk($sformatf("c%0d.rdy_after_rst", g), chunk_rdy, 1'b1);
         rand_chunk();
         offer(1'b0);
         drain();
         perf_check();
         done = 1'b1;
      end
   end

   initial begin : p_main
      logic [63:0] m [16];
      logic [63:0] s [80];
      m = '{default: 64'h0};
      m[0]  = 64'h6162_6380;
      m[15] = 64'h18;
      build(32, m, s);
      chk("model32.w16", s[16], 64'h6162_6380);
      chk("model32.w17", s[17], 64'h000F_0000);
      m[0] = 64'h6162_6380_0000_0000;
      build(64, m, s);
      chk("model64.w16", s[16], 64'h6162_6380_0000_0000);
      chk("model64.w17", s[17], 64'h0003_0000_0000_00C0);
      m = '{default: 64'h0};
      build(64, m, s);
      chk("model64.zero", s[79], 64'h0);

      for (int k = 0; k < 20000; k++) begin
         @(posedge clk);
         if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
      end
      chk("all_done", g_cfg[0].done && g_cfg[1].done && g_cfg[2].done, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/msa_scheduler.md
# msa_scheduler

Parametrised, streaming SHA-2 message-schedule generator. It accepts one 16-word message chunk per handshake and emits the expanded schedule W[0..ROUNDS-1] as a stream of LANES words per beat, with valid/ready back-pressure. It sits between the chunk padder and the compression round engine. It serves SHA-224/256 (32-bit words) and SHA-384/512 (64-bit words). It keeps a rolling 16-word window instead of a full 64-word array.

## Interface
- WORD_W, 32, word width; legal values 32 (SHA-256 family) or 64 (SHA-512 family)
- LANES, 1, schedule words emitted per beat; legal values 1, 2, 4
- ROUNDS, derived (not overridable), 64 when WORD_W=32, 80 when WORD_W=64
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- chunk_vld  in  1  chunk_data valid
- chunk_rdy  out  1  block can accept a chunk this cycle
- chunk_data  in  16×WORD_W  message words; [0] is W[0]
- w_vld  out  1  w_data valid
- w_rdy  in  1  consumer accepts beat
- w_data  out  LANES×WORD_W  W[w_idx+j] in lane j
- w_idx  out  7  round index of lane 0
- w_last  out  1  final beat of the chunk (w_idx = ROUNDS-LANES)

## Operation
- States:
  - IDLE: waiting for a chunk.
  - STREAM: emitting beats.
- IDLE: chunk_rdy=1 and w_vld=0. On chunk_vld, load chunk_data into the 16-word window, clear w_idx, and go to STREAM.
- STREAM: w_vld=1. w_data holds window[0..LANES-1].
- On each beat handshake (w_vld&w_rdy):
  - Shift the window down by LANES.
  - Append LANES new words.
  - Add LANES to w_idx.
- New word t = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^WORD_W. The operands come from the window.
  - When LANES=4, lanes 2 and 3 use the freshly computed lanes 0 and 1 as W[t-2]. This forms a combinational chain in the same cycle.
- σ functions (ROTR = rotate right, SHR = logical shift right):
  - WORD_W=32: σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: σ0 = ROTR1^ROTR8^SHR7; σ1 = ROTR19^ROTR61^SHR6.
- Words generated past ROUNDS are computed but never presented.
- Last-beat handshake:
  - No chunk_vld: go to IDLE.
  - chunk_vld present: chunk_rdy is also 1, so chunk_rdy = IDLE | (w_vld&w_rdy&w_last). The new chunk is loaded and the block stays in STREAM with w_idx=0 (zero-bubble back-to-back).
- While w_vld=1 and w_rdy=0: w_data, w_idx and w_last hold stable; the window does not advance.
- Reset asserted mid-stream: the block in flight is dropped and w_vld falls asynchronously. After release the block is in IDLE.

## Timing
- Reset values: state=IDLE, w_vld=0, w_idx=0, w_last=0, chunk_rdy=0 while rst_n low. The window is not reset and w_data is don't-care while w_vld=0.
- chunk_rdy=1 from the first clk edge after rst_n deasserts.
- Latency: chunk accepted at edge N gives first beat (w_idx=0) valid after edge N, i.e. in cycle N+1.
- Throughput: ROUNDS/LANES beats per chunk; zero idle cycles between chunks when the source and sink never stall.
- chunk_rdy has a combinational path from w_rdy; w_vld, w_data, w_idx and w_last are register/window-driven only.

## Configuration
- MSA_SCHED_PERF_EN defined adds two outputs:
  - perf_chunks (32 bit): increments on each chunk handshake.
  - perf_stalls (32 bit): increments each cycle with w_vld&~w_rdy.
  - Both are reset to 0 by rst_n and wrap modulo 2^32.
- Undefined: both ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package sha2_pkg holds:
  - rightRotate32/rightRotate64 functions.
  - σ0/σ1 rotate and shift constants per word width.
  - ROUNDS lookup function.
  - MsaSchedState enum (IDLE, STREAM).
- Sub-module msa_sigma, parameterised by WORD_W, computes one new schedule word from its four operands. It is instantiated LANES times.

## Test plan
- WORD_W=32, LANES=1, chunk "abc" (W0=0x61626380, W1..W14=0, W15=0x00000018), w_rdy=1 -> 64 beats starting the cycle after accept. W16=0x61626380, W17=0x000F0000. All 64 words match the FIPS 180-4 model. w_last only on w_idx=63.
- All-zero chunk, WORD_W=64, LANES=4 -> 20 beats, all w_data=0, w_idx=0,4,…,76, w_last on 76.
- Random w_rdy (50%) with WORD_W=32, LANES=2 -> outputs stable during every stall, schedule matches the model. With MSA_SCHED_PERF_EN, perf_stalls equals the counted stall cycles.
- Two chunks offered back-to-back, w_rdy=1 -> second chunk's w_idx=0 beat immediately follows the first chunk's w_last beat (no gap); perf_chunks=2.
- rst_n pulsed low at w_idx=20 -> w_vld=0 immediately. After release, chunk_rdy=1 and a fresh chunk streams correctly from w_idx=0.
- chunk_vld held high during STREAM before the last beat -> no chunk is accepted until the w_last handshake.
